// File: rtl/e203_exu_brchmis_flush.sv
// ============================================================================
// Module      : e203_exu_brchmis_flush
// Description : Branch-mispredict / fence.i flush generator. Accepts a commit
//               from the branch/jump unit, decides whether the front end must
//               be redirected, computes the redirect PC and holds a flush
//               request towards the IFU until it is acknowledged.
//               Optional mispredict counter enabled by E203_BRCHMIS_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

`ifndef E203_XLEN
`define E203_XLEN 32
`endif

`default_nettype none

module e203_exu_brchmis_flush (
    input  logic                     clk,
    input  logic                     rst,

    // Commit interface from the branch/jump unit
    input  logic                     cmt_i_valid,
    output logic                     cmt_i_ready,
    input  logic                     cmt_i_bjp,
    input  logic                     cmt_i_fencei,
    input  logic                     cmt_i_prdt,
    input  logic                     cmt_i_rslv,
    input  logic                     cmt_i_jalr,
    input  logic                     cmt_i_rv32,
    input  logic [`E203_PC_SIZE-1:0] cmt_i_pc,
    input  logic [`E203_XLEN-1:0]    cmt_i_imm,
    input  logic [`E203_XLEN-1:0]    cmt_i_rs1,

    // Flush interface towards the IFU
    output logic                     flush_req,
    input  logic                     flush_ack,
    output logic [`E203_PC_SIZE-1:0] flush_pc,

    // Mispredict statistics
    output logic [31:0]              brchmis_cnt,
    input  logic                     cnt_clr
);

    localparam int PC_W = `E203_PC_SIZE;
    localparam int XLEN = `E203_XLEN;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [PC_W-1:0]   flush_pc_q;
    logic [PC_W-1:0]   flush_pc_d;

    logic              w_accept;
    logic              w_mispredict;
    logic              w_flush_cond;
    logic [PC_W-1:0]   w_pc_seq;
    logic [PC_W-1:0]   w_pc_taken;
    logic [XLEN-1:0]   w_jalr_sum;
    logic [PC_W-1:0]   w_pc_jalr;
    logic [PC_W-1:0]   w_target;

    // ------------------------------------------------------------------
    // Handshake and flush decision
    // ------------------------------------------------------------------
    // Ready is a pure function of state so the producer never sees a
    // combinational loop through cmt_i_valid.
    assign cmt_i_ready  = (state_q == ST_IDLE);
    assign w_accept     = cmt_i_valid & cmt_i_ready;
    assign w_mispredict = cmt_i_bjp & (cmt_i_prdt != cmt_i_rslv);
    assign w_flush_cond = w_mispredict | cmt_i_fencei;

    // ------------------------------------------------------------------
    // Redirect target candidates (all modulo 2^PC_W)
    // ------------------------------------------------------------------
    assign w_pc_seq   = cmt_i_pc + (cmt_i_rv32 ? PC_W'(4) : PC_W'(2));
    assign w_pc_taken = cmt_i_pc + PC_W'(cmt_i_imm);
    assign w_jalr_sum = cmt_i_rs1 + cmt_i_imm;
    // JALR targets always have bit 0 cleared.
    assign w_pc_jalr  = PC_W'(w_jalr_sum) & ~PC_W'(1);

    // Select the redirect PC; fence.i wins over any branch outcome.
    always_comb begin
        w_target = w_pc_seq;
        if (cmt_i_fencei) begin
            w_target = w_pc_seq;
        end else if (cmt_i_rslv) begin
            w_target = cmt_i_jalr ? w_pc_jalr : w_pc_taken;
        end else begin
            w_target = w_pc_seq;
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    // Next-state and redirect-PC capture; PC only updates on a flushing accept.
    always_comb begin
        state_d    = state_q;
        flush_pc_d = flush_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept && w_flush_cond) begin
                    state_d    = ST_FLUSH;
                    flush_pc_d = w_target;
                end
            end
            ST_FLUSH: begin
                if (flush_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and redirect-PC registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            flush_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    assign flush_req = (state_q == ST_FLUSH);
    assign flush_pc  = flush_pc_q;

    // ------------------------------------------------------------------
    // Mispredict counter (fence.i-only flushes are not counted)
    // ------------------------------------------------------------------
`ifdef E203_BRCHMIS_CNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Clear beats a same-cycle increment; the counter wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (w_accept && w_mispredict) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign brchmis_cnt = cnt_q;
`else
    // Counter removed: output tied low and clear input has no effect.
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign brchmis_cnt    = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/e203_exu_brchmis_flush.md
E203_EXU_BRCHMIS_FLUSH -- requirements
Module: e203_exu_brchmis_flush

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high (one clock, no other reset).
REQ-002 SHALL have: cmt_i_valid  in  1  commit request from BJP; cmt_i_ready  out  1  commit accepted.
REQ-003 SHALL have: cmt_i_bjp, cmt_i_fencei, cmt_i_prdt, cmt_i_rslv  in  1 each  BJP commit flags (branch/jump, fence.i, predicted taken, resolved taken).
REQ-004 SHALL have: cmt_i_jalr  in  1  JALR indicator; cmt_i_rv32  in  1  instruction is 32-bit (0 = 16-bit).
REQ-005 SHALL have: cmt_i_pc  in  `E203_PC_SIZE  instruction PC; cmt_i_imm, cmt_i_rs1  in  `E203_XLEN  offset and JALR base.
REQ-006 SHALL have: flush_req  out  1  flush request to IFU; flush_ack  in  1  IFU accepts flush; flush_pc  out  `E203_PC_SIZE  redirect target.
REQ-007 SHALL have: brchmis_cnt  out  32  mispredict count; cnt_clr  in  1  synchronous counter clear.

Function
REQ-008 SHALL implement two states: IDLE and FLUSH.
REQ-009 cmt_i_ready SHALL be 1 in IDLE and 0 in FLUSH (combinational from state only, no dependency on cmt_i_valid).
REQ-010 Accept = cmt_i_valid & cmt_i_ready; flush condition = (cmt_i_bjp & (cmt_i_prdt != cmt_i_rslv)) | cmt_i_fencei.
REQ-011 On accept with flush condition: next state FLUSH, flush_pc registered; otherwise state stays IDLE, flush_pc holds.
REQ-012 Target: rslv=1 & jalr -> (rs1 + imm) with bit 0 cleared; rslv=1 & !jalr -> pc + imm; rslv=0 or fencei -> pc + (rv32 ? 4 : 2).
REQ-013 fencei SHALL take priority over bjp in target selection when both are set.
REQ-014 Additions SHALL be modulo 2^`E203_PC_SIZE (wrap-around, no overflow flag); immediate used at full width.
REQ-015 flush_req SHALL be 1 exactly while in FLUSH; first asserted the cycle after accept (latency 1).
REQ-016 flush_pc SHALL be stable while flush_req=1.
REQ-017 In FLUSH with flush_ack=1: next state IDLE; cmt_i_ready returns to 1 the following cycle.
REQ-018 flush_ack while in IDLE SHALL be ignored.
REQ-019 Back-to-back: a commit presented in the cycle after ack is accepted normally; no commit is accepted in the ack cycle.

Reset
REQ-020 rst=1 SHALL force state IDLE, flush_req=0, flush_pc=0, brchmis_cnt=0 at the next clk edge.
REQ-021 Reset in FLUSH SHALL abandon the pending flush; no flush_req after reset deasserts until a new flush-causing accept.

Configuration
REQ-022 Macro E203_BRCHMIS_CNT_EN defined: brchmis_cnt increments by 1 on each accept with bjp & prdt!=rslv (fencei-only excluded), wraps 0xFFFFFFFF->0.
REQ-023 cnt_clr=1 SHALL zero the counter next cycle and take priority over a same-cycle increment.
REQ-024 Macro not defined: counter register absent; brchmis_cnt tied to 0; cnt_clr ignored; all other behaviour identical.

Verification
REQ-025 Branch predicted not-taken, resolved taken, pc=0x8000_0100, imm=0x40 -> next cycle flush_req=1, flush_pc=0x8000_0140, cmt_i_ready=0.
REQ-026 Predicted taken, resolved not-taken, pc=0x8000_0200, rv32=0 -> flush_pc=0x8000_0202; hold flush_ack=0 3 cycles -> flush_req, flush_pc stable; ack -> IDLE next cycle.
REQ-027 JALR rslv=1, prdt=0, rs1=0x1003, imm=0x10 -> flush_pc=0x1012; pc=0xFFFF_FFFC, imm=0x8, bxx -> flush_pc=0x0000_0004 (wrap).
REQ-028 Correctly predicted branch (prdt=rslv=1) -> no flush_req, cmt_i_ready stays 1, brchmis_cnt unchanged.
REQ-029 Assert rst in FLUSH -> flush_req=0, flush_pc=0, brchmis_cnt=0 next cycle; no flush after rst drops.
REQ-030 With E203_BRCHMIS_CNT_EN: 3 mispredicts + 1 fencei -> brchmis_cnt=3; cnt_clr with simultaneous mispredict -> 0.
